// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - per-channel synchronizer, debouncer and rise/fall/long-press pulse generator
module input_debouncer #(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] long_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1, s2;
        state_t        state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic [HW-1:0] hcnt, hcnt_nx;
        logic          level_q, rise_q, fall_q, lp_q;
        logic          level_nx, rise_nx, fall_nx, lp_nx;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1      <= 1'b0;
                s2      <= 1'b0;
                state   <= LOW;
                cnt     <= '0;
                hcnt    <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                lp_q    <= 1'b0;
            end else begin
                s1      <= sw_in[i];
                s2      <= s1;
                state   <= state_nx;
                cnt     <= cnt_nx;
                hcnt    <= hcnt_nx;
                level_q <= level_nx;
                rise_q  <= rise_nx;
                fall_q  <= fall_nx;
                lp_q    <= lp_nx;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            hcnt_nx  = hcnt;
            rise_nx  = 1'b0;
            fall_nx  = 1'b0;
            lp_nx    = 1'b0;
            case (state)
                LOW: begin
                    if (s2) begin
                        state_nx = WAIT_HIGH;
                        cnt_nx   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state_nx = LOW;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = HIGH;
                        rise_nx  = 1'b1;
                        hcnt_nx  = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state_nx = WAIT_LOW;
                        cnt_nx   = '0;
                    end else if (hcnt != HOLD_MAX) begin
                        // saturating: the pulse can only fire on the single step into HOLD_MAX
                        hcnt_nx = hcnt + 1'b1;
                        lp_nx   = (hcnt == HOLD_LAST);
                    end
                end
                WAIT_LOW: begin
                    // hcnt is deliberately left alone so a glitch cannot re-arm long_press
                    if (s2) begin
                        state_nx = HIGH;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = LOW;
                        fall_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = LOW;
            endcase
            level_nx = (state_nx == HIGH) || (state_nx == WAIT_LOW);
        end

        assign level[i]      = level_q;
        assign rise[i]       = rise_q;
        assign fall[i]       = fall_q;
        assign long_press[i] = lp_q;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Per-channel switch/button input conditioner for the board's slide switches and push-buttons. Each raw asynchronous input is synchronized, debounced and converted to a clean level plus single-cycle rise, fall and long-press pulses. Game and timer FSMs (the reaction timer and similar) consume these pulses instead of sampling raw switch pins. Runs on the 100 MHz system clock.

## Interface
- N, 2: number of independent input channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz); must be ≥ 2.
- HOLD_CYCLES, 100_000_000: cycles in accepted-high state before a long-press pulse (1 s); must be ≥ 2.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- sw_in  input  N  raw asynchronous switch/button levels, active-high.
- level  output  N  debounced level per channel.
- rise  output  N  one-cycle pulse when a channel's debounced level goes 0→1.
- fall  output  N  one-cycle pulse when a channel's debounced level goes 1→0.
- long_press  output  N  one-cycle pulse, at most once per press, after HOLD_CYCLES in the high state.

## Operation
- Channels are fully independent; all logic is replicated per channel.
- Synchronizer: two flops, sw_in → s1 → s2. The FSM sees only s2.
- Debounce counter cnt: width $clog2(DEBOUNCE_CYCLES). Hold counter hcnt: width $clog2(HOLD_CYCLES+1).
- States:
  - LOW: level=0. On s2=1 → WAIT_HIGH, cnt←0.
  - WAIT_HIGH: on s2=0 → LOW (bounce rejected, no pulse). On s2=1 with cnt==DEBOUNCE_CYCLES-1 → HIGH, level←1, rise←1, hcnt←0. Otherwise cnt←cnt+1.
  - HIGH: level=1. On s2=0 → WAIT_LOW, cnt←0. Otherwise hcnt increments, saturating at HOLD_CYCLES. long_press←1 only on the edge where hcnt goes HOLD_CYCLES-1→HOLD_CYCLES.
  - WAIT_LOW: level stays 1 and hcnt holds. On s2=1 → HIGH with no pulse; hcnt is not cleared, so long_press still fires at most once per press. On s2=0 with cnt==DEBOUNCE_CYCLES-1 → LOW, level←0, fall←1. Otherwise cnt←cnt+1.
- rise, fall and long_press are registered and default to 0 every cycle.
- rise and long_press can never assert in the same cycle.

## Timing
- Reset: state LOW, s1=s2=0, cnt=hcnt=0. level, rise, fall and long_press are all 0 the cycle after any clk edge with rst=1.
  - rst has priority over all other activity.
  - rst mid-debounce or mid-press aborts with no pulse.
- Accept latency: sw_in changes before edge k and stays stable. The level change and its rise/fall pulse are registered at edge k+DEBOUNCE_CYCLES+2.
- Minimum accepted width: sw_in must be stable for DEBOUNCE_CYCLES+1 consecutive sampling edges. One fewer is rejected with no output change.
- Any single opposite-level s2 sample during WAIT_HIGH or WAIT_LOW restarts the debounce.
- long_press timing: registered exactly HOLD_CYCLES edges after the rise edge, provided no WAIT_LOW excursion occurs. WAIT_LOW cycles do not count toward the hold.
- Input high through reset release: the channel starts in LOW and debounces normally. rise is registered at edge DEBOUNCE_CYCLES+2, counting the first non-reset edge as 0.
- Counter arithmetic is unsigned. Counters never wrap; hcnt saturates.

## Test plan
Bench parameters: N=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
- Reset: rst=1 for 3 cycles with sw_in=2'b11 → all outputs 0 throughout. Release rst → rise=2'b11 for exactly one cycle at edge 6 after release, level=2'b11 thereafter.
- Clean press ch0: sw_in[0] 0→1 before edge k, held → level[0]=1 and rise[0]=1 for one cycle at edge k+6; ch1 outputs stay 0.
- Bounce rejection: sw_in[0] high for 4 edges then low → no rise, level[0]=0. Repeat with 5 edges high → rise[0] at edge k+6, then fall[0] 6 edges after the drop.
- Long press: hold sw_in[0] 30 cycles → long_press[0] pulses once, exactly 10 edges after rise[0], never again during the press. A 5-cycle press → no long_press.
- Release glitch: while HIGH, drive sw_in[0] low for 2 cycles then high → no fall, no second rise, level stays 1, and the long_press count is unaffected by the excursion. Clean release afterwards → fall[0] at edge k+6 of the release.
- Reset mid-operation: assert rst during WAIT_HIGH on ch0 and during HIGH on ch1 → both level bits 0 next cycle, no rise/fall/long_press pulses emitted.
